// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates an instruction-fetch port and a
// load/store port onto a single 8-bit RAM, one byte per cycle.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_len,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic [31:0] ram_a,
  output logic [7:0]  ram_dout,
  output logic        ram_wr,
  input  logic [7:0]  ram_din,
  output logic        busy
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_mem_q, is_mem_d;
  logic [31:0] data_q, data_d;
  logic [31:0] ram_a_q, ram_a_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        ram_wr_q, ram_wr_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [2:0]  mem_n;

  assign mem_n = (mem_len == 2'd0) ? 3'd1 : (mem_len == 2'd1) ? 3'd2 : 3'd4;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    is_mem_d    = is_mem_q;
    data_d      = data_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_inst_d   = 32'd0;
    mem_rdata_d = 32'd0;
    case (state_q)
      S_IDLE: begin
        // Byte 0 is issued straight from the grant edge so it appears in cycle 1.
        if (mem_req) begin
          is_mem_d = 1'b1;
          base_d   = mem_addr;
          n_d      = mem_n;
          wdata_d  = mem_wdata;
          data_d   = 32'd0;
          cnt_d    = 3'd1;
          ram_a_d  = mem_addr;
          if (mem_we) begin
            state_d    = S_WRITE;
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
          end else begin
            state_d = S_READ;
          end
        end else if (if_req) begin
          is_mem_d = 1'b0;
          base_d   = if_addr;
          n_d      = 3'd4;
          data_d   = 32'd0;
          cnt_d    = 3'd1;
          ram_a_d  = if_addr;
          state_d  = S_READ;
        end
      end
      S_READ: begin
        // cnt_q is the cycle index after grant; byte i arrives in cycle i+2.
        cnt_d = cnt_q + 3'd1;
        if (cnt_q < n_q) ram_a_d = base_q + 32'(cnt_q);
        for (int i = 0; i < 4; i++)
          if (32'(cnt_q) == i + 2) data_d[8*i +: 8] = ram_din;
        if (cnt_q == n_q + 3'd1) begin
          state_d = S_DONE;
          if (is_mem_q) begin
            mem_done_d  = 1'b1;
            mem_rdata_d = data_d;
          end else begin
            if_done_d = 1'b1;
            if_inst_d = data_d;
          end
        end
      end
      S_WRITE: begin
        if (cnt_q < n_q) begin
          ram_a_d  = base_q + 32'(cnt_q);
          ram_wr_d = 1'b1;
          for (int i = 0; i < 4; i++)
            if (32'(cnt_q) == i) ram_dout_d = wdata_q[8*i +: 8];
          cnt_d = cnt_q + 3'd1;
        end else begin
          state_d    = S_DONE;
          mem_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      base_q      <= 32'd0;
      wdata_q     <= 32'd0;
      is_mem_q    <= 1'b0;
      data_q      <= 32'd0;
      ram_a_q     <= 32'd0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      is_mem_q    <= is_mem_d;
      data_q      <= data_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_inst   = if_inst_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;
  assign busy      = (state_q != S_IDLE);
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 if_req  in  1  fetch request, held until if_done.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_done  out  1  one-cycle pulse, fetch complete.
REQ-007 if_inst  out  32  fetched word, valid while if_done=1.
REQ-008 mem_req  in  1  load/store request, held until mem_done.
REQ-009 mem_we  in  1  1=store, 0=load.
REQ-010 mem_len  in  2  byte count: 0=1, 1=2, 2=4, 3=4.
REQ-011 mem_addr  in  32  data byte address.
REQ-012 mem_wdata  in  32  store data, little-endian.
REQ-013 mem_done  out  1  one-cycle pulse, load/store complete.
REQ-014 mem_rdata  out  32  load data, zero-extended, valid while mem_done=1.
REQ-015 ram_a  out  32  RAM byte address.
REQ-016 ram_dout  out  8  RAM write byte.
REQ-017 ram_wr  out  1  RAM write strobe.
REQ-018 ram_din  in  8  RAM read byte, valid one cycle after its address.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 FSM states: IDLE, READ, WRITE, DONE.
REQ-021 IDLE: samples requests at each edge; mem_req has priority over if_req.
REQ-022 Grant edge: latch address, byte count n, direction and wdata; if grant -> READ (n=4); mem grant -> READ or WRITE by mem_we.
REQ-023 Requests not preempted; lower-priority requester waits, its req held.
REQ-024 READ: cycles 1..n after grant drive ram_a = base+i for i=0..n-1, ram_wr=0.
REQ-025 READ: ram_din in cycle i+2 is captured into result byte i (bits 8i+7:8i).
REQ-026 READ: after capturing byte n-1, -> DONE; done pulse and data in cycle n+2 after grant (word: cycle 6).
REQ-027 WRITE: cycles 1..n drive ram_a = base+i, ram_dout = wdata[8i+7:8i], ram_wr=1; -> DONE; mem_done in cycle n+1.
REQ-028 DONE: lasts exactly one cycle; asserts only the granted requester's done; unrequested result bytes read as 0; -> IDLE.
REQ-029 DONE: requests ignored; arbitration resumes the following IDLE cycle.
REQ-030 Address arithmetic: base+i modulo 2^32 (wraps 0xFFFFFFFF -> 0x00000000).
REQ-031 Request deasserted mid-transaction: transaction completes; done still pulsed.
REQ-032 ram_wr=0 in every state except WRITE.
REQ-033 Inputs changed after grant: no effect on current transaction.

Reset
REQ-034 rst=1 at an edge: state IDLE, all outputs 0 (ram_a, ram_dout, ram_wr, done pulses, if_inst, mem_rdata, busy), counters cleared.
REQ-035 rst mid-transaction: transaction aborted, no done pulse, ram_wr=0 from the next cycle.

Verification
REQ-036 if_req, if_addr=0x100, RAM[0x100..0x103]=13 05 00 00 -> ram_a 0x100..0x103 in cycles 1..4, if_done cycle 6, if_inst=0x00000513.
REQ-037 if_req and mem_req (load, len=0, addr=0x20, RAM=0xFF) same edge -> mem_done cycle 3 with mem_rdata=0x000000FF; fetch then granted, if_done follows.
REQ-038 Store len=1, addr=0x40, wdata=0xAABBCCDD -> ram_wr=1 with (0x40,DD),(0x41,CC) in cycles 1-2, mem_done cycle 3, RAM[0x42] unchanged.
REQ-039 Load len=2, addr=0xFFFFFFFE -> ram_a sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
REQ-040 rst asserted during cycle 3 of a word store -> ram_wr=0 next cycle, no mem_done, busy=0, subsequent request served normally.
